mult_issue_seq: RTL and testbench

- Command sequencer directly upstream of the radix-4 Booth multiplier.
- Buffers signed 16-bit operand pairs in a small FIFO and issues them one at a time using the multiplier's start/busy/irq/ack handshake.
- Collects each 32-bit product and presents it on a valid/ready output port to the consuming logic.
- Includes a watchdog so a stuck multiplier cannot hang the pipeline.

---
 rtl/mult_issue_seq.sv | 204 ++++++++++++++++++++
 tb/tb_mult_issue_seq.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_issue_seq.sv
// mult_issue_seq: operand FIFO and issue sequencer in front of the radix-4 Booth
// multiplier. Pops one operand pair at a time, runs the start/busy/irq/ack
// handshake with a watchdog, and holds each product on a valid/ready port.
module mult_issue_seq #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 63
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [15:0]              in_a,
    input  logic [15:0]              in_b,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_result,
    output logic                     out_error,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     mul_start,
    output logic [15:0]              mul_a,
    output logic [15:0]              mul_b,
    output logic                     mul_irq_enable,
    output logic                     mul_ack,
    input  logic                     mul_busy,
    input  logic                     mul_irq,
    input  logic [31:0]              mul_result
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    // Watchdog only needs to count 0..TIMEOUT-1
    localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_ACK,
        S_OUTPUT
    } state_t;

    state_t          state_q, state_d;

    logic [31:0]     mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]   level_q, level_d;
    logic [31:0]     head;
    logic            push;
    logic            pop;

    logic [WW-1:0]   wd_q, wd_d;
    logic [15:0]     mul_a_q, mul_a_d;
    logic [15:0]     mul_b_q, mul_b_d;
    logic            mul_start_q, mul_start_d;
    logic            mul_ack_q, mul_ack_d;
    logic            out_valid_q, out_valid_d;
    logic [31:0]     out_result_q, out_result_d;
    logic            out_error_q, out_error_d;
    logic            irq_en_q;

    // in_ready looks at pre-pop occupancy, so a full FIFO refuses a push even
    // in the cycle the FSM pops it
    assign in_ready = (level_q != LW'(DEPTH));
    assign push     = in_valid && in_ready;
    assign head     = mem_q[rd_ptr_q];

    // FIFO storage write; contents need no reset since level gates every read
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {in_a, in_b};
        end
    end

    // FIFO pointer and occupancy next-state; pop is requested by the FSM
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (push && !pop) begin
            level_d = level_q + LW'(1);
        end else if (pop && !push) begin
            level_d = level_q - LW'(1);
        end
    end

    // FIFO pointer and occupancy registers
    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Sequencer next-state and registered-output logic
    always_comb begin
        state_d      = state_q;
        pop          = 1'b0;
        mul_start_d  = 1'b0;
        mul_a_d      = mul_a_q;
        mul_b_d      = mul_b_q;
        mul_ack_d    = mul_ack_q;
        wd_d         = wd_q;
        out_valid_d  = out_valid_q;
        out_result_d = out_result_q;
        out_error_d  = out_error_q;
        case (state_q)
            S_IDLE: begin
                if (level_q != '0 && !mul_busy) begin
                    mul_a_d     = head[31:16];
                    mul_b_d     = head[15:0];
                    mul_start_d = 1'b1;
                    pop         = 1'b1;
                    state_d     = S_ISSUE;
                end
            end
            S_ISSUE: begin
                wd_d    = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // irq is tested first so it wins over a same-cycle timeout
                if (mul_irq) begin
                    out_result_d = mul_result;
                    out_error_d  = 1'b0;
                    mul_ack_d    = 1'b1;
                    state_d      = S_ACK;
                end else if (wd_q == WW'(TIMEOUT - 1)) begin
                    out_result_d = '0;
                    out_error_d  = 1'b1;
                    mul_ack_d    = 1'b1;
                    state_d      = S_ACK;
                end else begin
                    wd_d = wd_q + WW'(1);
                end
            end
            S_ACK: begin
                if (!mul_busy && !mul_irq) begin
                    mul_ack_d   = 1'b0;
                    out_valid_d = 1'b1;
                    state_d     = S_OUTPUT;
                end
            end
            S_OUTPUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Sequencer state and output registers
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q      <= S_IDLE;
            wd_q         <= '0;
            mul_a_q      <= '0;
            mul_b_q      <= '0;
            mul_start_q  <= 1'b0;
            mul_ack_q    <= 1'b0;
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            out_error_q  <= 1'b0;
            irq_en_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            wd_q         <= wd_d;
            mul_a_q      <= mul_a_d;
            mul_b_q      <= mul_b_d;
            mul_start_q  <= mul_start_d;
            mul_ack_q    <= mul_ack_d;
            out_valid_q  <= out_valid_d;
            out_result_q <= out_result_d;
            out_error_q  <= out_error_d;
            irq_en_q     <= 1'b1;
        end
    end

    assign level          = level_q;
    assign mul_start      = mul_start_q;
    assign mul_a          = mul_a_q;
    assign mul_b          = mul_b_q;
    assign mul_ack        = mul_ack_q;
    assign mul_irq_enable = irq_en_q;
    assign out_valid      = out_valid_q;
    assign out_result     = out_result_q;
    assign out_error      = out_error_q;

endmodule

// File: tb/tb_mult_issue_seq.sv
// tb_mult_issue_seq: scoreboard bench for mult_issue_seq with a behavioural
// multiplier model, directed scenarios and a randomized phase.
module tb_mult_issue_seq;

    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 63;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] in_a = '0;
    logic [15:0] in_b = '0;
    logic        out_ready = 1'b0;
    logic        mul_busy = 1'b0;
    logic        mul_irq = 1'b0;
    logic [31:0] mul_result = '0;

    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_result;
    logic        out_error;
    logic [2:0]  level;
    logic        mul_start;
    logic [15:0] mul_a;
    logic [15:0] mul_b;
    logic        mul_irq_enable;
    logic        mul_ack;

    always #5 clk = ~clk;

    mult_issue_seq #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .resetn(resetn),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_error(out_error), .level(level),
        .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
        .mul_irq_enable(mul_irq_enable), .mul_ack(mul_ack),
        .mul_busy(mul_busy), .mul_irq(mul_irq), .mul_result(mul_result)
    );

    typedef struct packed { logic [15:0] a; logic [15:0] b; } pair_t;
    typedef struct packed { logic e; logic [31:0] r; } res_t;

    int    checks = 0;
    int    errors = 0;
    pair_t fifo_m[$];      // operand pairs accepted but not yet issued
    res_t  expq[$];        // results expected on the output port, in order

    // multiplier model and scenario controls
    int          stuck_cnt = 0;
    int          lat_fix = 0;
    bit          hold_busy = 1'b0;
    bit          m_active = 1'b0;
    bit          m_stuck = 1'b0;
    int          m_cnt = 0;
    logic [31:0] m_res = '0;

    // monitor history
    logic        prev_ov = 1'b0;
    logic        prev_ack = 1'b0;
    logic        prev_start = 1'b0;
    logic        prev_err = 1'b0;
    logic [31:0] prev_res = '0;
    bit          wd_track = 1'b0;
    int          wd_cnt = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endfunction

    function automatic void flag(input string name);
        checks++;
        errors++;
        $display("FAIL %s: actual event seen required none", name);
    endfunction

    // Monitor + multiplier model. At each negedge the inputs still hold the
    // values the DUT sampled at the preceding posedge.
    initial begin
        pair_t p;
        res_t  e;
        int    prod;
        forever begin
            @(negedge clk);
            if (!resetn) begin
                chk("rst_flags", 32'({out_valid, out_error, mul_start, mul_ack, mul_irq_enable}), 32'(0));
                chk("rst_out_result", out_result, 32'(0));
                chk("rst_mul_ab", {mul_a, mul_b}, 32'(0));
                chk("rst_level", 32'(level), 32'(0));
                fifo_m.delete();
                expq.delete();
                m_active = 1'b0;
                m_stuck  = 1'b0;
                wd_track = 1'b0;
                mul_irq  = 1'b0;
            end else begin
                chk("irq_enable", 32'(mul_irq_enable), 32'(1));

                if (prev_ov && out_ready) begin
                    chk("out_valid_drop", 32'(out_valid), 32'(0));
                    if (expq.size() == 0) begin
                        flag("out_unexpected");
                    end else begin
                        e = expq.pop_front();
                        chk("out_result", prev_res, e.r);
                        chk("out_error", 32'(prev_err), 32'(e.e));
                    end
                end else if (prev_ov) begin
                    chk("stall_valid", 32'(out_valid), 32'(1));
                    chk("stall_result", out_result, prev_res);
                    chk("stall_error", 32'(out_error), 32'(prev_err));
                end

                if (prev_ack) begin
                    if (!mul_busy && !mul_irq) begin
                        chk("ack_release", 32'(mul_ack), 32'(0));
                        chk("valid_after_ack", 32'(out_valid), 32'(1));
                    end else begin
                        chk("ack_hold", 32'(mul_ack), 32'(1));
                    end
                end else if (mul_ack && !m_active) begin
                    flag("ack_spurious");
                end

                if (prev_start) begin
                    chk("start_pulse", 32'(mul_start), 32'(0));
                end
                if (mul_start) begin
                    chk("start_while_valid", 32'(out_valid), 32'(0));
                    if (fifo_m.size() == 0) begin
                        flag("issue_unexpected");
                    end else begin
                        p = fifo_m.pop_front();
                        chk("mul_a", 32'(mul_a), 32'(p.a));
                        chk("mul_b", 32'(mul_b), 32'(p.b));
                        if (stuck_cnt > 0) begin
                            stuck_cnt--;
                            m_stuck  = 1'b1;
                            wd_track = 1'b1;
                            wd_cnt   = 0;
                            expq.push_back(res_t'({1'b1, 32'h0}));
                        end else begin
                            m_stuck = 1'b0;
                            prod = int'($signed(p.a)) * int'($signed(p.b));
                            expq.push_back(res_t'({1'b0, prod}));
                        end
                    end
                end

                if (wd_track && !mul_start) begin
                    if (mul_ack) begin
                        chk("timeout_cycles", 32'(wd_cnt), 32'(TIMEOUT));
                        wd_track = 1'b0;
                    end else begin
                        wd_cnt++;
                        if (wd_cnt > TIMEOUT + 4) begin
                            flag("timeout_missing");
                            wd_track = 1'b0;
                        end
                    end
                end

                chk("level", 32'(level), 32'(fifo_m.size()));

                // multiplier model: busy from start until ack, irq after latency
                if (m_active) begin
                    if (mul_ack) begin
                        m_active = 1'b0;
                        mul_irq  = 1'b0;
                    end else if (m_stuck) begin
                        mul_result = $urandom;
                    end else if (!mul_irq) begin
                        if (m_cnt > 1) begin
                            m_cnt--;
                        end else begin
                            mul_irq    = 1'b1;
                            mul_result = m_res;
                        end
                    end
                end else if (mul_start) begin
                    m_active = 1'b1;
                    m_cnt    = (lat_fix > 0) ? lat_fix : int'($urandom_range(1, 4));
                    prod     = int'($signed(mul_a)) * int'($signed(mul_b));
                    m_res    = prod;
                end
            end
            mul_busy   = m_active || hold_busy;
            prev_ov    = out_valid;
            prev_res   = out_result;
            prev_err   = out_error;
            prev_ack   = mul_ack;
            prev_start = mul_start;
        end
    end

    task automatic cycle(input bit v, input logic [15:0] a, input logic [15:0] b, input bit rdy);
        @(negedge clk);
        #1;
        in_valid  = v;
        in_a      = a;
        in_b      = b;
        out_ready = rdy;
        chk("in_ready", 32'(in_ready), 32'(fifo_m.size() < DEPTH));
        if (v && fifo_m.size() < DEPTH) begin
            fifo_m.push_back(pair_t'({a, b}));
        end
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((fifo_m.size() != 0 || expq.size() != 0 || out_valid || m_active) && n < budget) begin
            cycle(1'b0, 16'h0, 16'h0, 1'b1);
            n++;
        end
        checks++;
        if (n >= budget) begin
            errors++;
            $display("FAIL drain_timeout: actual %0d pending required 0", fifo_m.size() + expq.size());
        end
        cycle(1'b0, 16'h0, 16'h0, 1'b1);
        chk("level_drained", 32'(level), 32'(0));
    endtask

    initial begin
        int n;
        repeat (3) cycle(1'b0, 16'h0, 16'h0, 1'b1);
        resetn = 1'b1;
        cycle(1'b0, 16'h0, 16'h0, 1'b1);

        // basic products, positive and negative
        cycle(1'b1, 16'd3, 16'd5, 1'b1);
        drain(200);
        cycle(1'b1, 16'hFFFE, 16'h0007, 1'b1);
        drain(200);

        // fill while the multiplier is busy; fifth pair must be refused
        hold_busy = 1'b1;
        repeat (2) cycle(1'b0, 16'h0, 16'h0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 16'(i + 1), 16'(100 + i), 1'b1);
        end
        cycle(1'b0, 16'h0, 16'h0, 1'b1);
        chk("level_full", 32'(level), 32'(DEPTH));
        chk("in_ready_full", 32'(in_ready), 32'(0));
        hold_busy = 1'b0;
        drain(400);

        // stuck multiplier: watchdog error result, then the next pair proceeds
        stuck_cnt = 1;
        cycle(1'b1, 16'd7, 16'd9, 1'b1);
        cycle(1'b1, 16'hFFFC, 16'd6, 1'b1);
        drain(600);

        // consumer stall with a queued pair behind it
        cycle(1'b1, 16'd10, 16'd10, 1'b0);
        n = 0;
        while (!out_valid && n < 50) begin
            cycle(1'b0, 16'h0, 16'h0, 1'b0);
            n++;
        end
        chk("stall_reached", 32'(out_valid), 32'(1));
        cycle(1'b1, 16'd2, 16'd3, 1'b0);
        repeat (9) cycle(1'b0, 16'h0, 16'h0, 1'b0);
        chk("stall_value", out_result, 32'h64);
        drain(200);

        // reset while the multiplier is in flight with two pairs queued
        lat_fix = 30;
        cycle(1'b1, 16'd4, 16'd4, 1'b1);
        cycle(1'b1, 16'd5, 16'd5, 1'b1);
        cycle(1'b1, 16'd6, 16'd6, 1'b1);
        repeat (6) cycle(1'b0, 16'h0, 16'h0, 1'b1);
        chk("level_pre_reset", 32'(level), 32'(2));
        resetn = 1'b0;
        cycle(1'b0, 16'h0, 16'h0, 1'b1);
        resetn  = 1'b1;
        lat_fix = 0;
        repeat (5) cycle(1'b0, 16'h0, 16'h0, 1'b1);
        cycle(1'b1, 16'hFFFD, 16'h0003, 1'b1);
        drain(200);

        // randomized traffic with back-pressure and one stuck operation
        for (int i = 0; i < 400; i++) begin
            if (i == 150) stuck_cnt = 1;
            cycle($urandom_range(0, 99) < 50, 16'($urandom), 16'($urandom),
                  $urandom_range(0, 99) < 70);
        end
        drain(2000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: actual running required finished");
        $fatal(1, "simulation time limit");
    end

endmodule
